// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: bus owner per cycle and
// the owner of a read whose data returns on the following cycle.
package dmem_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE     = 2'd0,
    OWN_CPU      = 2'd1,
    OWN_DMA      = 2'd2,
    OWN_DMA_LOCK = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DMA  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the MEM stage and a loader/debug DMA.
// CPU has priority; a starved DMA is force-granted and a locked DMA burst keeps the port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wrtData,
  output logic          mem_MemRead,
  output logic          mem_MemWrt,
  input  logic [DW-1:0] mem_readData
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  owner_e            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  rd_owner_e         rd_owner_reg, rd_owner_next;
  logic              cpu_granted, dma_granted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= OWN_NONE;
      wait_cnt_reg <= '0;
      rd_owner_reg <= RD_NONE;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // Grant priority: held lock, then starvation override, then CPU, then idle-bus DMA.
  always_comb begin
    cpu_granted   = 1'b0;
    dma_granted   = 1'b0;
    state_next    = OWN_NONE;
    wait_cnt_next = wait_cnt_reg;
    rd_owner_next = RD_NONE;

    if (state_reg == OWN_DMA_LOCK && dma_req) begin
      dma_granted = 1'b1;
    end else if (dma_req && wait_cnt_reg == WAIT_LIMIT) begin
      dma_granted = 1'b1;
    end else if (cpu_req) begin
      cpu_granted = 1'b1;
    end else if (dma_req) begin
      dma_granted = 1'b1;
    end

    if (dma_granted) begin
      state_next = dma_lock ? OWN_DMA_LOCK : OWN_DMA;
    end else if (cpu_granted) begin
      state_next = OWN_CPU;
    end

    if (dma_granted) begin
      wait_cnt_next = '0;
    end else if (dma_req && wait_cnt_reg < WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end

    if (dma_granted && !dma_we) begin
      rd_owner_next = RD_DMA;
    end else if (cpu_granted && !cpu_we) begin
      rd_owner_next = RD_CPU;
    end
  end

  // Everything visible is forced low while reset is held, including the comb paths.
  always_comb begin
    cpu_stall   = 1'b0;
    dma_gnt     = 1'b0;
    mem_address = '0;
    mem_wrtData = '0;
    mem_MemRead = 1'b0;
    mem_MemWrt  = 1'b0;
    cpu_rdata   = '0;
    dma_rvalid  = 1'b0;
    dma_rdata   = '0;

    if (rst) begin
      cpu_stall = cpu_req && !cpu_granted;
      dma_gnt   = dma_granted;

      if (dma_granted) begin
        mem_address = dma_addr;
        mem_wrtData = dma_wdata;
        mem_MemWrt  = dma_we;
        mem_MemRead = !dma_we;
      end else begin
        mem_address = cpu_addr;
        mem_wrtData = cpu_wdata;
        mem_MemWrt  = cpu_granted && cpu_we;
        mem_MemRead = cpu_granted && !cpu_we;
      end

      if (rd_owner_reg == RD_CPU) begin
        cpu_rdata = mem_readData;
      end
      if (rd_owner_reg == RD_DMA) begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_readData;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter with a registered-read memory model
// and a behavioural arbitration/return reference.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [15:0] mem_address, mem_wrtData, mem_readData;
  logic        mem_MemRead, mem_MemWrt;

  dmem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_wrtData(mem_wrtData),
    .mem_MemRead(mem_MemRead), .mem_MemWrt(mem_MemWrt), .mem_readData(mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 257) ^ 16'h5A5A;
  endfunction

  // Environment memory: synchronous write, registered read.
  logic [15:0] tb_mem [256];
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
    end else begin
      if (mem_MemWrt) tb_mem[mem_address[7:0]] <= mem_wrtData;
      if (mem_MemRead) mem_readData <= tb_mem[mem_address[7:0]];
    end
  end

  // Reference state: memory image, DMA losing streak, lock ownership, pending return.
  logic [15:0] ref_mem [256];
  int          losses;
  bit          locked;
  bit          pend_cpu, pend_dma;
  logic [15:0] pend_val;
  bit          exp_last_dma, exp_last_cpu;
  bit          obs_gnt, obs_stall;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks at posedge+4, returns at next posedge+1.
  task automatic cycle(input bit creq, input bit cwe, input logic [15:0] caddr, input logic [15:0] cwd,
                       input bit dreq, input bit dwe, input logic [15:0] daddr, input logic [15:0] dwd,
                       input bit dlock);
    bit          e_dma, e_cpu, win, we;
    logic [15:0] addr, wd;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_lock = dlock;

    e_dma = dreq && (locked || losses >= MAX_WAIT || !creq);
    e_cpu = creq && !e_dma;
    win   = e_dma || e_cpu;
    we    = e_dma ? dwe : cwe;
    addr  = e_dma ? daddr : caddr;
    wd    = e_dma ? dwd : cwd;

    #3;
    obs_gnt   = dma_gnt;
    obs_stall = cpu_stall;
    chk("dma_gnt", dma_gnt, e_dma);
    chk("cpu_stall", cpu_stall, creq && !e_cpu);
    chk("mem_MemWrt", mem_MemWrt, win && we);
    chk("mem_MemRead", mem_MemRead, win && !we);
    if (win) chk("mem_address", mem_address, addr);
    if (win && we) chk("mem_wrtData", mem_wrtData, wd);
    chk("dma_rvalid", dma_rvalid, pend_dma);
    if (pend_cpu) chk("cpu_rdata", cpu_rdata, pend_val);
    if (pend_dma) chk("dma_rdata", dma_rdata, pend_val);
    $display("cyc=%0d cpu(req=%0b we=%0b a=%h) dma(req=%0b we=%0b a=%h lk=%0b) gnt=%0b stall=%0b crd=%h drv=%0b drd=%h",
             cyc, creq, cwe, caddr, dreq, dwe, daddr, dlock, dma_gnt, cpu_stall, cpu_rdata, dma_rvalid, dma_rdata);

    @(posedge clk); #1;
    cyc++;
    pend_cpu = e_cpu && !cwe;
    pend_dma = e_dma && !dwe;
    pend_val = ref_mem[addr[7:0]];
    if (win && we) ref_mem[addr[7:0]] = wd;
    locked = e_dma && dlock;
    if (e_dma) losses = 0;
    else if (dreq && losses < MAX_WAIT) losses++;
    exp_last_dma = e_dma;
    exp_last_cpu = e_cpu;
  endtask

  task automatic idle();
    cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_stall"}, cpu_stall, 0);
    chk({tag, "_gnt"}, dma_gnt, 0);
    chk({tag, "_rvalid"}, dma_rvalid, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_dma_rdata"}, dma_rdata, 0);
    chk({tag, "_memrd"}, mem_MemRead, 0);
    chk({tag, "_memwr"}, mem_MemWrt, 0);
    chk({tag, "_addr"}, mem_address, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          gnt_at, burst;
    bit          d_act, d_we, d_lk, c_req, c_we, c_hold;
    logic [15:0] d_a, d_wd, c_a, c_wd;

    rst = 1'b0; mem_ready = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    losses = 0; locked = 0; pend_cpu = 0; pend_dma = 0; pend_val = '0;

    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1; dma_req = 1; cpu_addr = 16'h0033;
    #3;
    reset_check("reset");
    @(posedge clk); #1;
    mem_ready = 1'b1;
    rst = 1'b1;

    // Test 1: CPU-only write then read back
    cycle(1, 1, 16'd4, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
    cycle(1, 0, 16'd4, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    chk("t1_cpu_rdata", cpu_rdata, 16'h1234);
    idle();

    // Test 2: CPU reads every cycle, DMA read @8 starves until forced
    gnt_at = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 16'(i + 16), 16'h0, 1, 0, 16'd8, 16'h0, 0);
      if (obs_gnt) begin gnt_at = i; break; end
    end
    chk("t2_grant_cycle", gnt_at, 4);
    chk("t2_dma_rvalid", dma_rvalid, 1);
    chk("t2_dma_rdata", dma_rdata, init_val(8));
    idle();

    // Test 3: locked DMA write burst against a requesting CPU
    burst = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 16'd1, 16'h0, 1, 1, 16'd0, 16'hDEAD, 1);
      if (obs_gnt) begin burst = 1; break; end
    end
    cycle(1, 0, 16'd1, 16'h0, 1, 1, 16'd2, 16'hDEAD, 1);
    if (obs_gnt && obs_stall) burst++;
    cycle(1, 0, 16'd1, 16'h0, 1, 1, 16'd6, 16'hDEAD, 1);
    if (obs_gnt && obs_stall) burst++;
    chk("t3_burst_grants", burst, 3);
    cycle(1, 0, 16'd1, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    chk("t3_cpu_after_stall", obs_stall, 0);

    // Test 4: alternating CPU read @0 / DMA read @6
    cycle(1, 1, 16'd0, 16'h0BEE, 0, 0, 16'h0, 16'h0, 0);
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 16'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      chk("t4_cpu_rdata", cpu_rdata, 16'h0BEE);
      chk("t4_cpu_no_dma", dma_rvalid, 0);
      cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'd6, 16'h0, 0);
      chk("t4_dma_rvalid", dma_rvalid, 1);
      chk("t4_dma_rdata", dma_rdata, 16'hDEAD);
    end

    // Test 5: reset while a DMA read is in flight
    cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'd8, 16'h0, 0);
    rst = 1'b0;
    cpu_req = 1; dma_req = 1; dma_lock = 1; cpu_addr = 16'd4;
    pend_cpu = 0; pend_dma = 0; locked = 0; losses = 0;
    #3;
    reset_check("t5_mid");
    @(posedge clk); #3;
    reset_check("t5_hold");
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1, 0, 16'd4, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    chk("t5_cpu_rdata", cpu_rdata, 16'h1234);
    chk("t5_no_dma", dma_rvalid, 0);

    // Test 6: no requests
    idle();
    idle();
    chk("t6_memrd", mem_MemRead, 0);
    chk("t6_memwr", mem_MemWrt, 0);
    chk("t6_rvalid", dma_rvalid, 0);

    // Random traffic: DMA holds its request until granted, CPU holds while stalled
    d_act = 0; d_we = 0; d_lk = 0; d_a = '0; d_wd = '0;
    c_hold = 0; c_req = 0; c_we = 0; c_a = '0; c_wd = '0;
    for (int n = 0; n < 300; n++) begin
      if (!d_act && $urandom_range(0, 1) == 1) begin
        d_act = 1;
        d_we  = 1'($urandom_range(0, 1));
        d_a   = 16'($urandom_range(0, 63));
        d_wd  = 16'($urandom);
        d_lk  = ($urandom_range(0, 2) == 0);
      end
      if (!c_hold) begin
        c_req = ($urandom_range(0, 2) != 0);
        c_we  = 1'($urandom_range(0, 1));
        c_a   = 16'($urandom_range(0, 63));
        c_wd  = 16'($urandom);
      end
      cycle(c_req, c_we, c_a, c_wd, d_act, d_we, d_a, d_wd, d_act && d_lk);
      c_hold = c_req && !exp_last_cpu;
      if (exp_last_dma) begin
        d_act = 0;
        if (d_lk && $urandom_range(0, 1) == 1) begin
          d_act = 1;
          d_we  = 1'($urandom_range(0, 1));
          d_a   = 16'($urandom_range(0, 63));
          d_wd  = 16'($urandom);
        end
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
